pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Fetch-side controller for the program counter register. Each cycle it decides whether the PC advances, holds, or takes a branch target. It produces the PC's next value plus its `stall_i`/`PCWrite_i` controls, the IF/ID write and flush controls, and a saturating stall-cycle counter for performance checks. It sits between the hazard unit, the ID-stage branch comparator and the data-cache handshake on one side, and the PC register and IF/ID latch on the other.

## Interface
Parameters:
- `INSTR_BYTES`, 4: sequential PC increment.
- `CNT_W`, 32: stall counter width.

Ports:
- `clk_i`  in  1  clock; all state on rising edge.
- `rst_i`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  CPU run enable.
- `pc_i`  in  32  current PC (from PC register output).
- `load_use_i`  in  1  load-use hazard from hazard unit (ID stage).
- `branch_i`  in  1  branch resolved taken in ID.
- `branch_target_i`  in  32  taken-branch target.
- `mem_req_i`  in  1  MEM stage issuing data-cache access this cycle.
- `mem_ack_i`  in  1  data cache access complete this cycle.
- `pc_next_o`  out  32  next PC value (to PC `pc_i`).
- `pc_write_o`  out  1  to PC `PCWrite_i`; 0 zeroes PC.
- `stall_o`  out  1  to PC `stall_i`; 1 holds PC.
- `ifid_write_o`  out  1  IF/ID latch enable.
- `ifid_flush_o`  out  1  IF/ID bubble insert.
- `state_o`  out  2  current FSM state (registered).
- `stall_cycles_o`  out  CNT_W  saturating count of stall cycles (registered).

## Operation
- States: IDLE=0, RUN=1, MEM_WAIT=2. Encoding 3 is illegal and recovers to IDLE on the next edge.
- IDLE: `pc_write_o`=0, `stall_o`=0 (PC forced to 0), `ifid_write_o`=0, `ifid_flush_o`=1. Goes to RUN when `start_i`=1.
- RUN and MEM_WAIT: `pc_write_o`=1. Per-cycle priority:
  1. Memory stall when `mem_req_i`&!`mem_ack_i` (RUN) or !`mem_ack_i` (MEM_WAIT). Drives `stall_o`=1, `ifid_write_o`=0, `ifid_flush_o`=0. Branch and load-use are ignored; their sources are frozen, so they re-present after the stall.
  2. Load-use: `stall_o`=1, `ifid_write_o`=0, `ifid_flush_o`=0.
  3. Taken branch: `stall_o`=0, `pc_next_o`=`branch_target_i`, `ifid_write_o`=1, `ifid_flush_o`=1.
  4. Otherwise: `pc_next_o`=`pc_i`+`INSTR_BYTES` (mod 2^32, wraps 0xFFFFFFFC→0), `ifid_write_o`=1, `ifid_flush_o`=0.
- `pc_next_o` defaults to `pc_i`+`INSTR_BYTES` whenever no branch is taken, including in IDLE.
- Transitions:
  - RUN→MEM_WAIT when `mem_req_i`&!`mem_ack_i`.
  - MEM_WAIT→RUN on `mem_ack_i`. The ack cycle itself is not stalled and lower priorities apply.
  - RUN→IDLE when `start_i`=0.
  - MEM_WAIT ignores `start_i` until ack; it then goes to IDLE if `start_i`=0, else RUN.
- Counter: +1 each cycle `stall_o`=1. Holds at all-ones (no wrap). Not cleared by IDLE; cleared only by reset.

## Timing
- All control outputs and `pc_next_o` are combinational from state and inputs, with zero latency.
- `state_o` and `stall_cycles_o` are registered and reflect the previous edge.
- Reset (async assert, sync-to-clock deassert by the system): state=IDLE, `stall_cycles_o`=0. Outputs are then `pc_write_o`=0, `stall_o`=0, `ifid_write_o`=0, `ifid_flush_o`=1.
- Reset mid-MEM_WAIT abandons the access immediately. The next `mem_ack_i` is ignored unless it arrives in a MEM_WAIT cycle.
- A single-cycle cache hit (`mem_req_i`&`mem_ack_i` together) causes no stall and no state change.
- `start_i` rising in IDLE: the first RUN cycle follows the next edge. PC is 0 at that point and advances to 4 on the following edge.

## Structure
- Shared `cpu_pkg`: state enum (IDLE/RUN/MEM_WAIT) and `INSTR_BYTES` default.
- One sub-module, `sat_counter` (parameter width; `en`, async active-low reset, saturating), for `stall_cycles_o`. The FSM and output decode stay in `pc_sequencer`.

## Test plan
- Reset then `start_i`=1, no hazards, 4 cycles: `pc_next_o` = 4, 8, 12, 16 with `pc_i` fed back. `stall_cycles_o`=0.
- RUN, `mem_req_i`=1, ack after 3 cycles: `stall_o`=1 for exactly 3 cycles, `state_o`=2 during the wait, counter=3. PC holds, then resumes.
- `load_use_i`=1 and `branch_i`=1 (target 0x100) in the same cycle: first cycle is a stall. With `load_use_i` dropped next cycle, `pc_next_o`=0x100 and `ifid_flush_o`=1.
- Memory stall with `branch_i` held: no redirect until the ack cycle, then `pc_next_o`=target.
- `start_i` dropped in MEM_WAIT: stays MEM_WAIT until ack, then IDLE with `pc_write_o`=0. Reset asserted mid-wait: immediate IDLE, counter=0.
- `pc_i`=0xFFFFFFFC sequential: `pc_next_o`=0. Counter forced near max with `CNT_W`=4: sticks at 15.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : cpu_pkg
//  Description : Shared types and constants for the CPU fetch-side control.
//                Holds the pc_sequencer state encoding and the default
//                sequential PC increment.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  // Default byte distance between sequential instructions.
  localparam int unsigned c_instr_bytes = 4;

  // Sequencer states; encoding 2'd3 is illegal and recovers to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter that increments when en is high and sticks at
//                all-ones instead of wrapping. Cleared only by reset.
//  Ports       : clk_i   - clock, rising edge
//                rst_i   - asynchronous active-low reset
//                en      - count enable
//                count_o - current count (registered)
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_count <= '0;
    end else if (en && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count_o = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer
//  Description : Fetch-side PC controller. Each cycle decides whether the PC
//                advances, holds (memory stall / load-use) or takes the ID
//                branch target, and drives the IF/ID write/flush controls.
//                Also keeps a saturating count of stall cycles.
//  Ports       : clk_i, rst_i (async active-low)
//                start_i          - CPU run enable
//                pc_i             - current PC
//                load_use_i       - load-use hazard
//                branch_i         - branch taken in ID
//                branch_target_i  - taken-branch target
//                mem_req_i        - MEM stage data-cache access this cycle
//                mem_ack_i        - data-cache access complete this cycle
//                pc_next_o        - next PC value
//                pc_write_o       - PC write enable (0 zeroes the PC)
//                stall_o          - hold PC
//                ifid_write_o     - IF/ID latch enable
//                ifid_flush_o     - IF/ID bubble insert
//                state_o          - current state (registered)
//                stall_cycles_o   - saturating stall count (registered)
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned INSTR_BYTES = c_instr_bytes,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [31:0]      pc_i,
  input  logic             load_use_i,
  input  logic             branch_i,
  input  logic [31:0]      branch_target_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  output logic [31:0]      pc_next_o,
  output logic             pc_write_o,
  output logic             stall_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cycles_o
);

  state_t r_state;

  logic w_in_run;
  logic w_in_wait;
  logic w_active;
  logic w_mem_stall;
  logic w_stall;
  logic w_take_branch;

  // --------------------------------------------------------------------------
  // State register. A memory miss in RUN takes priority over start_i going
  // low: the outstanding access must complete before the CPU can idle.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_i) r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (mem_req_i && !mem_ack_i) r_state <= ST_MEM_WAIT;
          else if (!start_i)           r_state <= ST_IDLE;
        end
        ST_MEM_WAIT: begin
          if (mem_ack_i) r_state <= start_i ? ST_RUN : ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output decode. The illegal encoding decodes like IDLE (all w_in_* low).
  // --------------------------------------------------------------------------
  assign w_in_run  = (r_state == ST_RUN);
  assign w_in_wait = (r_state == ST_MEM_WAIT);
  assign w_active  = w_in_run | w_in_wait;

  // In MEM_WAIT the request is already in flight, so only the ack matters;
  // the ack cycle itself falls through to the lower priorities.
  assign w_mem_stall = (w_in_run & mem_req_i & ~mem_ack_i) |
                       (w_in_wait & ~mem_ack_i);

  assign w_stall       = w_active & (w_mem_stall | load_use_i);
  assign w_take_branch = w_active & ~w_stall & branch_i;

  assign pc_next_o    = w_take_branch ? branch_target_i
                                      : (pc_i + 32'(INSTR_BYTES));
  assign pc_write_o   = w_active;
  assign stall_o      = w_stall;
  assign ifid_write_o = w_active & ~w_stall;
  assign ifid_flush_o = ~w_active | w_take_branch;
  assign state_o      = r_state;

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_stall_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en      (w_stall),
    .count_o (stall_cycles_o)
  );

endmodule : pc_sequencer
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_sequencer
//  Description : Scoreboard bench for pc_sequencer. A stimulus process drives
//                directed and random cycles, predicts each cycle's outputs
//                from a behavioural model and queues them; a monitor pops
//                and compares on the falling edge. A second instance with a
//                4-bit counter shares the stimulus to exercise saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] pc;
  logic        load_use;
  logic        branch;
  logic [31:0] target;
  logic        mem_req;
  logic        mem_ack;

  logic [31:0] pc_next, pc_next4;
  logic        pc_write, pc_write4;
  logic        stall, stall4;
  logic        ifid_write, ifid_write4;
  logic        ifid_flush, ifid_flush4;
  logic [1:0]  state, state4;
  logic [31:0] cnt;
  logic [3:0]  cnt4;

  pc_sequencer #(.INSTR_BYTES(4), .CNT_W(32)) dut (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .pc_i(pc),
    .load_use_i(load_use), .branch_i(branch), .branch_target_i(target),
    .mem_req_i(mem_req), .mem_ack_i(mem_ack),
    .pc_next_o(pc_next), .pc_write_o(pc_write), .stall_o(stall),
    .ifid_write_o(ifid_write), .ifid_flush_o(ifid_flush),
    .state_o(state), .stall_cycles_o(cnt)
  );

  pc_sequencer #(.INSTR_BYTES(4), .CNT_W(4)) dut4 (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .pc_i(pc),
    .load_use_i(load_use), .branch_i(branch), .branch_target_i(target),
    .mem_req_i(mem_req), .mem_ack_i(mem_ack),
    .pc_next_o(pc_next4), .pc_write_o(pc_write4), .stall_o(stall4),
    .ifid_write_o(ifid_write4), .ifid_flush_o(ifid_flush4),
    .state_o(state4), .stall_cycles_o(cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc_next;
    logic        pc_write;
    logic        stall;
    logic        ifid_write;
    logic        ifid_flush;
    logic [1:0]  state;
    logic [31:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // ---------------- behavioural model ----------------
  // Mode: 0 idle, 1 running, 2 waiting on data cache.
  int          m_mode = 0;
  longint      m_stalls = 0;     // unbounded stall count
  logic [31:0] m_pc = 32'd0;     // model of the PC register feeding pc_i

  task automatic cyc(input logic s, input logic lu, input logic br,
                     input logic [31:0] tg, input logic rq, input logic ak);
    exp_t e;
    bit   running, miss, hold, redirect;
    @(posedge clk);
    #1;
    start = s; load_use = lu; branch = br; target = tg;
    mem_req = rq; mem_ack = ak; pc = m_pc;

    running  = (m_mode != 0);
    miss     = (m_mode == 1 && rq && !ak) || (m_mode == 2 && !ak);
    hold     = running && (miss || lu);
    redirect = running && !hold && br;

    e.pc_next    = redirect ? tg : m_pc + 32'd4;
    e.pc_write   = running;
    e.stall      = hold;
    e.ifid_write = running && !hold;
    e.ifid_flush = !running || redirect;
    e.state      = 2'(m_mode);
    e.cnt        = (m_stalls > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(m_stalls);
    e.cnt4       = (m_stalls > 15) ? 4'd15 : 4'(m_stalls);
    q.push_back(e);

    if (hold) m_stalls++;
    if (!running)  m_pc = 32'd0;
    else if (!hold) m_pc = e.pc_next;

    case (m_mode)
      0: if (s) m_mode = 1;
      1: if (rq && !ak) m_mode = 2; else if (!s) m_mode = 0;
      default: if (ak) m_mode = s ? 1 : 0;
    endcase
  endtask

  // Assert reset for n cycles; the first cycle asserts right after an edge
  // so the async clear is visible at the following falling edge.
  task automatic do_reset(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      start = 0; load_use = 0; branch = 0; target = 0;
      mem_req = 0; mem_ack = 0;
      m_mode = 0; m_stalls = 0; m_pc = 32'd0; pc = 32'd0;
      e.pc_next = 32'd4; e.pc_write = 0; e.stall = 0; e.ifid_write = 0;
      e.ifid_flush = 1; e.state = 2'd0; e.cnt = 32'd0; e.cnt4 = 4'd0;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- monitor ----------------
  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: actual %h required %h", nm, $time, act, req);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pc_next",      pc_next,            e.pc_next);
        chk("pc_write",     32'(pc_write),      32'(e.pc_write));
        chk("stall",        32'(stall),         32'(e.stall));
        chk("ifid_write",   32'(ifid_write),    32'(e.ifid_write));
        chk("ifid_flush",   32'(ifid_flush),    32'(e.ifid_flush));
        chk("state",        32'(state),         32'(e.state));
        chk("stall_cycles", cnt,                e.cnt);
        chk("cnt4",         32'(cnt4),          32'(e.cnt4));
        chk("small_ctrl",   {27'd0, stall4, pc_write4, ifid_write4,
                             ifid_flush4, 1'b0},
                            {27'd0, e.stall, e.pc_write, e.ifid_write,
                             e.ifid_flush, 1'b0});
        chk("small_pc",     pc_next4,           e.pc_next);
        chk("small_state",  32'(state4),        32'(e.state));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    start = 0; load_use = 0; branch = 0; target = 0;
    mem_req = 0; mem_ack = 0; pc = 0;

    do_reset(2);

    // Start and run sequentially: PC 0 -> 4 -> 8 -> 12 -> 16.
    repeat (6) cyc(1, 0, 0, 32'h0, 0, 0);

    // Data-cache miss acked after 3 stalled cycles.
    cyc(1, 0, 0, 32'h0, 1, 0);
    repeat (2) cyc(1, 0, 0, 32'h0, 1, 0);
    cyc(1, 0, 0, 32'h0, 1, 1);
    cyc(1, 0, 0, 32'h0, 0, 0);

    // Single-cycle hit: no stall, no state change.
    cyc(1, 0, 0, 32'h0, 1, 1);

    // Load-use beats branch, then branch redirects.
    cyc(1, 1, 1, 32'h100, 0, 0);
    cyc(1, 0, 1, 32'h100, 0, 0);
    cyc(1, 0, 0, 32'h0, 0, 0);

    // Memory stall with a branch held until the ack cycle.
    cyc(1, 0, 1, 32'h200, 1, 0);
    cyc(1, 0, 1, 32'h200, 1, 0);
    cyc(1, 0, 1, 32'h200, 1, 1);
    cyc(1, 0, 0, 32'h0, 0, 0);

    // start dropped during MEM_WAIT: wait for ack, then IDLE.
    cyc(1, 0, 0, 32'h0, 1, 0);
    cyc(0, 0, 0, 32'h0, 1, 0);
    cyc(0, 0, 0, 32'h0, 1, 1);
    cyc(0, 0, 0, 32'h0, 0, 0);

    // Restart, miss, then reset mid-wait; a stray ack afterwards is ignored.
    cyc(1, 0, 0, 32'h0, 0, 0);
    cyc(1, 0, 0, 32'h0, 1, 0);
    cyc(1, 0, 0, 32'h0, 1, 0);
    do_reset(1);
    cyc(0, 0, 0, 32'h0, 0, 1);
    cyc(1, 0, 0, 32'h0, 0, 1);
    cyc(1, 0, 0, 32'h0, 0, 0);

    // PC wrap at the top of the address space.
    m_pc = 32'hFFFF_FFFC;
    cyc(1, 0, 0, 32'h0, 0, 0);
    cyc(1, 0, 0, 32'h0, 0, 0);

    // Drive the 4-bit counter past its ceiling.
    repeat (20) cyc(1, 1, 0, 32'h0, 0, 0);
    cyc(1, 0, 0, 32'h0, 0, 0);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 9) != 0),
          ($urandom_range(0, 4) == 0),
          ($urandom_range(0, 4) == 0),
          {$urandom_range(0, 32'h3FFF), 2'b00},
          ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 4) < 2));
    end

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: actual %0d pending required 0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pc_sequencer
`default_nettype wire
